// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and sizing helpers for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

    // A 2-bit operand still needs one counter bit to tell bit 0 from bit 1.
    function automatic int cnt_width(input int width);
        return (width <= MIN_WIDTH) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational 1-bit full adder from two half-adder stages
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic hs1;
    logic hc1;
    logic hc2;

    assign hs1 = a ^ b;
    assign hc1 = a & b;
    assign s   = hs1 ^ ci;
    assign hc2 = hs1 & ci;
    assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial add/subtract with start/busy/done handshake
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa (
        .a  (opa_q[0]),
        .b  (opb_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        part_d  = part_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                part_d  = WIDTH'({fa_s, part_q} >> 1);
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB, fa_co the carry out of it.
                    sum_d   = part_d;
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at widths 2, 8, 17 and 64
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;

    logic [3:0]  busy_w;
    logic [3:0]  done_w;
    logic [65:0] res_w [4];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g
        localparam int W = (gi == 0) ? 2 : (gi == 1) ? 8 : (gi == 2) ? 17 : 64;

        logic         busy_i, done_i, cout_i, ovf_i;
        logic [W-1:0] sum_i;

        serial_adder #(.WIDTH(W)) dut (
            .clk   (clk),
            .rst   (rst),
            .start (start),
            .sub   (sub),
            .a     (a[W-1:0]),
            .b     (b[W-1:0]),
            .busy  (busy_i),
            .done  (done_i),
            .sum   (sum_i),
            .cout  (cout_i),
            .ovf   (ovf_i)
        );

        assign busy_w[gi] = busy_i;
        assign done_w[gi] = done_i;
        assign res_w[gi]  = 66'({ovf_i, cout_i, sum_i});

        // Reference: {ovf, cout, result} from plain integer arithmetic.
        function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic s);
            logic [W:0]   t;
            logic [W-1:0] r;
            logic         c, v;
            if (!s) begin
                t = {1'b0, x} + {1'b0, y};
                r = t[W-1:0];
                c = t[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end else begin
                r = x - y;
                c = (x >= y);
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            return {v, c, r};
        endfunction

        // age: -1 idle, else edges since the accepting edge
        int           age = -1;
        logic [W-1:0] ma = '0, mb = '0;
        logic         msub = 1'b0;
        logic [W+1:0] e_res = '0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                age   <= -1;
                e_res <= '0;
            end else if (age >= 0) begin
                if (age == W - 1) e_res <= ref_op(ma, mb, msub);
                age <= (age == W) ? -1 : age + 1;
            end else if (start) begin
                ma   <= a[W-1:0];
                mb   <= b[W-1:0];
                msub <= sub;
                age  <= 0;
            end
        end

        always @(negedge clk) begin
            chk($sformatf("w%0d_busy", W), 66'(busy_i), 66'(age >= 0 && age < W));
            chk($sformatf("w%0d_done", W), 66'(done_i), 66'(age == W));
            chk($sformatf("w%0d_result", W), 66'({ovf_i, cout_i, sum_i}), 66'(e_res));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (((|busy_w) || (|done_w)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 66'(n), 66'(0));
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (!done_w[1] && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) chk("done_timeout", 66'(n), 66'(8));
    endtask

    task automatic run_op(input string nm, input logic [63:0] av, input logic [63:0] bv,
                          input logic sv, input logic [9:0] exp);
        int n;
        wait_idle();
        a = av; b = bv; sub = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done8(n);
        chk({nm, "_latency"}, 66'(n), 66'(8));
        chk({nm, "_value"}, 66'(res_w[1][9:0]), 66'(exp));
    endtask

    initial begin
        int n, cnt, last, cyc;

        repeat (3) @(negedge clk);
        chk("reset_result", res_w[1], 66'(0));
        chk("reset_busy_done", 66'({busy_w, done_w}), 66'(0));
        #2 rst = 1'b0;

        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(|busy_w) + int'(|done_w);
        end
        chk("idle_no_activity", 66'(cnt), 66'(0));

        run_op("add_3c_05", 64'h3C, 64'h05, 1'b0, {1'b0, 1'b0, 8'h41});
        run_op("add_7f_01", 64'h7F, 64'h01, 1'b0, {1'b1, 1'b0, 8'h80});
        run_op("add_ff_01", 64'hFF, 64'h01, 1'b0, {1'b0, 1'b1, 8'h00});
        run_op("sub_05_07", 64'h05, 64'h07, 1'b1, {1'b0, 1'b0, 8'hFE});
        run_op("sub_80_01", 64'h80, 64'h01, 1'b1, {1'b1, 1'b1, 8'h7F});

        // Stray starts in RUN and DONE, operands changed mid-RUN.
        wait_idle();
        a = 64'h3C; b = 64'h05; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 64'hFF; b = 64'hFF; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done8(n);
        chk("hs_result", 66'(res_w[1][9:0]), 66'({1'b0, 1'b0, 8'h41}));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(done_w[1]);
        end
        chk("hs_no_extra_done", 66'(cnt), 66'(0));

        // Start held high: one completion every WIDTH+2 cycles.
        wait_idle();
        a = 64'h7F; b = 64'h01; sub = 1'b0; start = 1'b1;
        cnt = 0; last = -1;
        for (cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            if (done_w[1]) begin
                if (last >= 0) chk("b2b_interval", 66'(cyc - last), 66'(10));
                last = cyc;
                cnt++;
            end
        end
        start = 1'b0;
        chk("b2b_count", 66'(cnt), 66'(4));

        // Async reset in the middle of an operation.
        wait_idle();
        a = 64'h12; b = 64'h34; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_result", res_w[1], 66'(0));
        chk("midrst_busy", 66'(busy_w), 66'(0));
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("midrst_no_done", 66'(done_w), 66'(0));
        run_op("after_rst", 64'h3C, 64'h05, 1'b0, {1'b0, 1'b0, 8'h41});

        // Random operands at every width, start held high.
        wait_idle();
        start = 1'b1;
        repeat (500) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            sub = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1);
    end

endmodule
